// File: rtl/othello_pkg.sv
// Shared encodings, direction table, FSM states and address packing for the
// Othello board-update datapath.
package othello_pkg;

  localparam int BOARD_ADDR_W = 7;
  localparam int CELL_W       = 2;
  localparam int BOARD_DIM    = 8;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_BLACK = 2'b01;
  localparam cell_t CELL_WHITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_STEP,
    S_WAIT,
    S_CHECK,
    S_WRITEBACK,
    S_NEXT_DIR,
    S_DONE
  } flip_state_e;

  // Signed 2-bit deltas packed by direction index (index 0 in the low bits):
  // N, NE, E, SE, S, SW, W, NW.
  localparam logic [15:0] DIR_DR = 16'b11_00_01_01_01_00_11_11;
  localparam logic [15:0] DIR_DC = 16'b11_11_11_00_01_01_01_00;

  function automatic logic signed [1:0] dir_dr(input logic [2:0] d);
    return DIR_DR[{d, 1'b0} +: 2];
  endfunction

  function automatic logic signed [1:0] dir_dc(input logic [2:0] d);
    return DIR_DC[{d, 1'b0} +: 2];
  endfunction

  function automatic logic [BOARD_ADDR_W-1:0] pack_addr(input logic [2:0] row,
                                                         input logic [2:0] col);
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/flip_dir_step.sv
// Combinational neighbour lookup: one step from (row, col) along direction dir,
// flagging steps that leave the board.
module flip_dir_step
  import othello_pkg::*;
#(
  parameter int DIM = BOARD_DIM
) (
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [2:0] dir,
  output logic [2:0] next_row,
  output logic [2:0] next_col,
  output logic       off_board
);

  logic signed [1:0] dr;
  logic signed [1:0] dc;
  logic [4:0]        r_sum;
  logic [4:0]        c_sum;

  // A step below zero wraps to bit 4 set; a step past the edge lands >= DIM.
  always_comb begin
    dr        = dir_dr(dir);
    dc        = dir_dc(dir);
    r_sum     = {2'b00, row} + {{3{dr[1]}}, dr};
    c_sum     = {2'b00, col} + {{3{dc[1]}}, dc};
    off_board = r_sum[4] || c_sum[4] || (r_sum >= 5'(DIM)) || (c_sum >= 5'(DIM));
    next_row  = r_sum[2:0];
    next_col  = c_sum[2:0];
  end

endmodule

// File: rtl/flip_engine.sv
// Board-update stage: places a stone, then walks all 8 directions flipping
// bracketed opponent runs. Optional flip_count output under `FLIP_COUNT_EN.
module flip_engine
  import othello_pkg::*;
#(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int DATA_W = CELL_W,
  parameter int DIM    = BOARD_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        pos,
  input  logic [DATA_W-1:0] color,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr_flip,
  output logic [DATA_W-1:0] data_flip,
  output logic              wren_flip,
  output logic              flip_ctrl,
  output logic              busy,
  output logic              done
`ifdef FLIP_COUNT_EN
  ,
  output logic [4:0]        flip_count
`endif
);

  flip_state_e       state;
  flip_state_e       state_n;
  logic [5:0]        pos_q;
  logic [DATA_W-1:0] color_q;
  logic [2:0]        cur_row;
  logic [2:0]        cur_col;
  logic [2:0]        dir;
  logic [2:0]        run;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        nxt_row;
  logic [2:0]        nxt_col;
  logic              off_board;
  logic              color_ok;
  logic              is_opp;
  logic              is_own;

  flip_dir_step #(
    .DIM(DIM)
  ) u_step (
    .row      (cur_row),
    .col      (cur_col),
    .dir      (dir),
    .next_row (nxt_row),
    .next_col (nxt_col),
    .off_board(off_board)
  );

  always_comb begin
    color_ok = (color == CELL_BLACK) || (color == CELL_WHITE);
    is_opp   = (rd_data == ((color_q == CELL_BLACK) ? CELL_WHITE : CELL_BLACK));
    is_own   = (rd_data == color_q);
  end

  // Address/data are driven from the holding registers unless a state needs
  // the bus, so the RAM keeps seeing the last address between accesses.
  always_comb begin
    state_n   = state;
    addr_flip = addr_q;
    data_flip = data_q;
    wren_flip = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    flip_ctrl = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_n = color_ok ? S_PLACE : S_DONE;
      end
      S_PLACE: begin
        addr_flip = ADDR_W'(pack_addr(pos_q[5:3], pos_q[2:0]));
        data_flip = color_q;
        wren_flip = 1'b1;
        state_n   = S_STEP;
      end
      S_STEP: begin
        if (off_board) begin
          state_n = S_NEXT_DIR;
        end else begin
          addr_flip = ADDR_W'(pack_addr(nxt_row, nxt_col));
          state_n   = S_WAIT;
        end
      end
      S_WAIT: state_n = S_CHECK;
      S_CHECK: begin
        if (is_opp)                      state_n = S_STEP;
        else if (is_own && (run != '0))  state_n = S_WRITEBACK;
        else                             state_n = S_NEXT_DIR;
      end
      S_WRITEBACK: begin
        addr_flip = ADDR_W'(pack_addr(nxt_row, nxt_col));
        data_flip = color_q;
        wren_flip = 1'b1;
        if (run == 3'd1) state_n = S_NEXT_DIR;
      end
      S_NEXT_DIR: state_n = (dir == 3'd7) ? S_DONE : S_STEP;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pos_q   <= '0;
      color_q <= '0;
      cur_row <= '0;
      cur_col <= '0;
      dir     <= '0;
      run     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_flip;
      data_q <= data_flip;
      case (state)
        S_IDLE: begin
          if (start) begin
            pos_q   <= pos;
            color_q <= color;
          end
        end
        S_PLACE: begin
          dir     <= '0;
          run     <= '0;
          cur_row <= pos_q[5:3];
          cur_col <= pos_q[2:0];
        end
        S_CHECK: begin
          if (is_opp) begin
            run     <= run + 3'd1;
            cur_row <= nxt_row;
            cur_col <= nxt_col;
          end else if (is_own && (run != '0)) begin
            cur_row <= pos_q[5:3];
            cur_col <= pos_q[2:0];
          end
        end
        S_WRITEBACK: begin
          run     <= run - 3'd1;
          cur_row <= nxt_row;
          cur_col <= nxt_col;
        end
        S_NEXT_DIR: begin
          run     <= '0;
          cur_row <= pos_q[5:3];
          cur_col <= pos_q[2:0];
          if (dir != 3'd7) dir <= dir + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FLIP_COUNT_EN
  logic [4:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (state == S_IDLE && start) cnt_q <= '0;
    else if (state == S_WRITEBACK)     cnt_q <= cnt_q + 5'd1;
  end

  assign flip_count = cnt_q;
`endif

endmodule

// File: tb/tb_flip_engine.sv
// Directed bench for flip_engine with a one-cycle-latency board RAM model.
module tb_flip_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] pos;
  logic [1:0] color;
  logic [1:0] rd_data;
  logic [6:0] addr_flip;
  logic [1:0] data_flip;
  logic       wren_flip;
  logic       flip_ctrl;
  logic       busy;
  logic       done;
`ifdef FLIP_COUNT_EN
  logic [4:0] flip_count;
`endif

  logic [1:0] mem        [64];
  logic [1:0] board_init [64];
  logic       load = 1'b0;
  logic [6:0] wr_addr    [256];
  logic [1:0] wr_data    [256];
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         total    = 0;
  int         bad      = 0;

  flip_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pos      (pos),
    .color    (color),
    .rd_data  (rd_data),
    .addr_flip(addr_flip),
    .data_flip(data_flip),
    .wren_flip(wren_flip),
    .flip_ctrl(flip_ctrl),
    .busy     (busy),
    .done     (done)
`ifdef FLIP_COUNT_EN
    ,
    .flip_count(flip_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM plus a log of every write and done pulse.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= board_init[i];
    end else if (wren_flip) begin
      mem[addr_flip[5:0]] <= data_flip;
    end
    rd_data <= mem[addr_flip[5:0]];
    if (wren_flip) begin
      wr_addr[wr_cnt % 256] <= addr_flip;
      wr_data[wr_cnt % 256] <= data_flip;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board_init[i] = 2'b00;
  endtask

  task automatic load_board();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_move(input logic [5:0] p, input logic [1:0] c, output bit finished);
    @(negedge clk);
    pos   = p;
    color = c;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    pos   = '0;
    color = '0;
    clear_board();
    load_board();
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (flip_ctrl !== 1'b0) begin bad++; $display("FAIL reset_flip_ctrl got=%b want=0", flip_ctrl); end
    total++; if (wren_flip !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b want=0", wren_flip); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (addr_flip !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr_flip); end
    total++; if (data_flip !== 2'b00) begin bad++; $display("FAIL reset_data got=%b want=00", data_flip); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd0) begin bad++; $display("FAIL reset_flip_count got=%0d want=0", flip_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_opening();
    int w0, d0;
    bit fin;
    clear_board();
    board_init[27] = 2'b10; board_init[28] = 2'b01;
    board_init[35] = 2'b01; board_init[36] = 2'b10;
    load_board();
    w0 = wr_cnt; d0 = done_cnt;
    run_move(6'd19, 2'b01, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL opening_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL opening_done_count got=%0d want=1", done_cnt - d0); end
    total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL opening_write_count got=%0d want=2", wr_cnt - w0); end
    total++; if (wr_addr[w0 % 256] !== 7'd19 || wr_data[w0 % 256] !== 2'b01) begin
      bad++; $display("FAIL opening_write0 got=%0d/%b want=19/01", wr_addr[w0 % 256], wr_data[w0 % 256]); end
    total++; if (wr_addr[(w0 + 1) % 256] !== 7'd27 || wr_data[(w0 + 1) % 256] !== 2'b01) begin
      bad++; $display("FAIL opening_write1 got=%0d/%b want=27/01", wr_addr[(w0 + 1) % 256], wr_data[(w0 + 1) % 256]); end
    total++; if (mem[27] !== 2'b01) begin bad++; $display("FAIL opening_cell27 got=%b want=01", mem[27]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL opening_idle_busy got=%b want=0", busy); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd1) begin bad++; $display("FAIL opening_flip_count got=%0d want=1", flip_count); end
`endif
  endtask

  task automatic test_corner_empty();
    int w0, d0;
    bit fin;
    clear_board();
    load_board();
    w0 = wr_cnt; d0 = done_cnt;
    run_move(6'd0, 2'b10, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL corner_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (wr_cnt - w0 != 1) begin bad++; $display("FAIL corner_write_count got=%0d want=1", wr_cnt - w0); end
    total++; if (wr_addr[w0 % 256] !== 7'd0 || wr_data[w0 % 256] !== 2'b10) begin
      bad++; $display("FAIL corner_write0 got=%0d/%b want=0/10", wr_addr[w0 % 256], wr_data[w0 % 256]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL corner_done_count got=%0d want=1", done_cnt - d0); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd0) begin bad++; $display("FAIL corner_flip_count got=%0d want=0", flip_count); end
`endif
  endtask

  task automatic test_max_run();
    int w0;
    bit fin;
    clear_board();
    for (int i = 1; i <= 6; i++) board_init[i] = 2'b01;
    board_init[7] = 2'b10;
    load_board();
    w0 = wr_cnt;
    run_move(6'd0, 2'b10, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL maxrun_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (wr_cnt - w0 != 7) begin bad++; $display("FAIL maxrun_write_count got=%0d want=7", wr_cnt - w0); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (wr_addr[(w0 + i) % 256] !== 7'(i) || wr_data[(w0 + i) % 256] !== 2'b10) begin
        bad++; $display("FAIL maxrun_write%0d got=%0d/%b want=%0d/10", i, wr_addr[(w0 + i) % 256], wr_data[(w0 + i) % 256], i);
      end
    end
    total++; if (mem[7] !== 2'b10) begin bad++; $display("FAIL maxrun_cell7 got=%b want=10", mem[7]); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd6) begin bad++; $display("FAIL maxrun_flip_count got=%0d want=6", flip_count); end
`endif
  endtask

  task automatic test_own_neighbour();
    int w0;
    bit fin;
    clear_board();
    board_init[9]  = 2'b01;
    board_init[8]  = 2'b10;
    board_init[16] = 2'b01;
    load_board();
    w0 = wr_cnt;
    run_move(6'd0, 2'b01, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL ownnb_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL ownnb_write_count got=%0d want=2", wr_cnt - w0); end
    total++; if (wr_addr[(w0 + 1) % 256] !== 7'd8 || wr_data[(w0 + 1) % 256] !== 2'b01) begin
      bad++; $display("FAIL ownnb_write1 got=%0d/%b want=8/01", wr_addr[(w0 + 1) % 256], wr_data[(w0 + 1) % 256]); end
    total++; if (mem[9] !== 2'b01) begin bad++; $display("FAIL ownnb_cell9 got=%b want=01", mem[9]); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd1) begin bad++; $display("FAIL ownnb_flip_count got=%0d want=1", flip_count); end
`endif
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    bit fin, seen;
    clear_board();
    board_init[27] = 2'b10; board_init[28] = 2'b01;
    board_init[35] = 2'b01; board_init[36] = 2'b10;
    load_board();
    w0 = wr_cnt;
    @(negedge clk);
    pos = 6'd19; color = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (flip_ctrl !== 1'b1) begin bad++; $display("FAIL busy_flip_ctrl got=%b want=1", flip_ctrl); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_busy got=%b want=1", busy); end
    repeat (5) @(negedge clk);
    pos = 6'd0; color = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin fin = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL busy_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL busy_write_count got=%0d want=2", wr_cnt - w0); end
    total++; if (wr_addr[(w0 + 1) % 256] !== 7'd27 || wr_data[(w0 + 1) % 256] !== 2'b01) begin
      bad++; $display("FAIL busy_write1 got=%0d/%b want=27/01", wr_addr[(w0 + 1) % 256], wr_data[(w0 + 1) % 256]); end
    // Reserved colour: done within two cycles, nothing written.
    w0 = wr_cnt; d0 = done_cnt;
    pos = 6'd5; color = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = done;
    if (!seen) begin
      @(negedge clk);
      seen = done;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL reserved_done got=%b want=1", seen); end
    repeat (3) @(negedge clk);
    total++; if (wr_cnt - w0 != 0) begin bad++; $display("FAIL reserved_writes got=%0d want=0", wr_cnt - w0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL reserved_done_count got=%0d want=1", done_cnt - d0); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd0) begin bad++; $display("FAIL reserved_flip_count got=%0d want=0", flip_count); end
`endif
  endtask

  task automatic test_reset_mid();
    int w0;
    bit fin, hit;
    clear_board();
    for (int i = 1; i <= 6; i++) board_init[i] = 2'b01;
    board_init[7] = 2'b10;
    load_board();
    @(negedge clk);
    pos = 6'd0; color = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wren_flip && addr_flip != 7'd0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL midrst_reach_writeback got=%b want=1", hit); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (flip_ctrl !== 1'b0) begin bad++; $display("FAIL midrst_flip_ctrl got=%b want=0", flip_ctrl); end
    total++; if (wren_flip !== 1'b0) begin bad++; $display("FAIL midrst_wren got=%b want=0", wren_flip); end
    @(negedge clk);
    rst = 1'b0;
    clear_board();
    board_init[27] = 2'b10; board_init[28] = 2'b01;
    board_init[35] = 2'b01; board_init[36] = 2'b10;
    load_board();
    w0 = wr_cnt;
    run_move(6'd19, 2'b01, fin);
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL midrst_restart_timeout got=%b want=1", fin); end
    @(negedge clk);
    total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL midrst_restart_writes got=%0d want=2", wr_cnt - w0); end
    total++; if (mem[27] !== 2'b01) begin bad++; $display("FAIL midrst_restart_cell27 got=%b want=01", mem[27]); end
`ifdef FLIP_COUNT_EN
    total++; if (flip_count !== 5'd1) begin bad++; $display("FAIL midrst_flip_count got=%0d want=1", flip_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_opening();
    test_corner_empty();
    test_max_run();
    test_own_neighbour();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
